// File: rtl/dmem_stream_reader.sv
// dmem_stream_reader: walks a block of consecutive data-memory words from a
// byte base address and serialises each word, least-significant byte first,
// onto a valid/ready byte stream. Reads only through the combinational
// read port (mem_addr/mem_rdata) and never touches the write port.
module dmem_stream_reader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LEN_W       = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    word_idx_reg;
  logic [LEN_W-1:0] words_left_reg;
  logic [1:0]       byte_idx_reg;
  logic [31:0]      word_buf_reg;

  logic handshake;
  logic final_word;

  // Only the word-index bits of the base address matter; the rest are
  // deliberately dropped (byte offset and out-of-range high bits).
  logic unused_base_bits;
  assign unused_base_bits = ^{base_addr[31:AW+2], base_addr[1:0]};

  assign handshake  = out_valid && out_ready;
  assign final_word = (words_left_reg == LEN_W'(1));

  // Address comes straight from the registered word index, so it is
  // glitch-free and steady for the whole SEND phase.
  assign mem_addr = {{(30-AW){1'b0}}, word_idx_reg, 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and Moore-style outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len_words != '0) state_next = FETCH;
          else                 state_next = DONE;
        end
      end
      FETCH: begin
        busy       = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = word_buf_reg[{byte_idx_reg, 3'b000} +: 8];
        out_last  = (byte_idx_reg == 2'd3) && final_word;
        if (out_ready && byte_idx_reg == 2'd3) begin
          if (final_word) state_next = DONE;
          else            state_next = FETCH;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: word pointer, remaining count, byte pointer and word latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx_reg   <= '0;
      words_left_reg <= '0;
      byte_idx_reg   <= 2'd0;
      word_buf_reg   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && len_words != '0) begin
            word_idx_reg   <= base_addr[AW+1:2];
            words_left_reg <= len_words;
          end
        end
        FETCH: begin
          // Word is captured here; later memory writes do not affect it.
          word_buf_reg <= mem_rdata;
          byte_idx_reg <= 2'd0;
        end
        SEND: begin
          if (handshake) begin
            if (byte_idx_reg != 2'd3) begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end else if (!final_word) begin
              words_left_reg <= words_left_reg - LEN_W'(1);
              word_idx_reg   <= word_idx_reg + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Scoreboard bench for dmem_stream_reader: stimulus pushes the expected byte
// stream (computed from a memory array model), an independent monitor pops
// and compares every accepted byte, and checks stalls and the done pulse.
module tb_dmem_stream_reader;
  localparam int DEPTH = 1024;
  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len_words;
  logic             busy, done;
  logic [31:0]      mem_addr, mem_rdata;
  logic             out_valid, out_ready, out_last;
  logic [7:0]       out_data;

  logic [31:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr[11:2]];

  dmem_stream_reader #(.DEPTH_WORDS(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .len_words(len_words), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  bit   mon_en = 0;
  bit   done_exp_next = 0;
  int   ready_mode = 0;
  int   rdy_phase = 0;
  bit   stall_prev = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  // Sink readiness: always ready, 1,0,0 pattern, or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares the presented stream against the scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done || done_exp_next) begin
        check("done_pulse", {31'b0, done}, {31'b0, done_exp_next});
        check("busy_in_done", {31'b0, busy}, 32'd1);
      end
      done_exp_next = 0;
      if (stall_prev) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_data", {24'b0, out_data}, {24'b0, prev_data});
        check("stall_last", {31'b0, out_last}, {31'b0, prev_last});
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid) begin
        check("busy_in_send", {31'b0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_byte got %h expected none", out_data);
        end else begin
          check("mem_addr", mem_addr, exp_q[0].addr);
          if (out_ready) begin
            e = exp_q.pop_front();
            check("byte", {24'b0, out_data}, {24'b0, e.data});
            check("last", {31'b0, out_last}, {31'b0, e.last});
            $display("byte %02h last %0d addr %h", out_data, out_last, mem_addr);
            hs_count++;
            if (e.last) done_exp_next = 1;
          end
        end
      end
    end
  end

  // Issue a start pulse; when push is set, model the expected stream.
  task automatic start_xfer(input logic [31:0] base, input int len, input bit push);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    len_words = LEN_W'(len);
    if (push) begin
      for (int i = 0; i < len; i++) begin
        int unsigned wi;
        logic [31:0] w;
        wi = (int'(base >> 2) + i) % DEPTH;
        w  = mem[wi];
        for (int b = 0; b < 4; b++) begin
          exp_t x;
          x.data = w[8*b +: 8];
          x.last = (i == len - 1) && (b == 3);
          x.addr = wi * 4;
          exp_q.push_back(x);
        end
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push && len == 0) done_exp_next = 1;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !busy && !done_exp_next) begin
        $display("transfer %s complete", name);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s got %0d pending expected 0", name, exp_q.size());
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base_addr = 32'h0;
    len_words = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_last", {31'b0, out_last}, 0);
    check("rst_data", {24'b0, out_data}, 0);
    check("rst_addr", mem_addr, 0);
    reset  = 1'b0;
    mon_en = 1;

    // Two words, sink always ready, with first-byte latency check.
    mem[4] = 32'hDDCCBBAA;
    mem[5] = 32'h44332211;
    ready_mode = 0;
    start_xfer(32'h10, 2, 1);
    check("fetch_no_valid", {31'b0, out_valid}, 0);
    check("fetch_busy", {31'b0, busy}, 1);
    @(posedge clk);
    #1;
    check("first_valid", {31'b0, out_valid}, 1);
    wait_idle("two_words");

    // Same transfer under 1,0,0 backpressure.
    ready_mode = 1;
    rdy_phase  = 0;
    start_xfer(32'h10, 2, 1);
    wait_idle("backpressure");

    // Wrap from the top word to word 0.
    mem[1023] = 32'h01020304;
    mem[0]    = 32'h0A0B0C0D;
    ready_mode = 2;
    start_xfer(32'hFFC, 2, 1);
    wait_idle("wrap");

    // Zero-length transfer: one busy cycle with done, no bytes.
    ready_mode = 0;
    start_xfer(32'h40, 0, 1);
    check("len0_busy", {31'b0, busy}, 1);
    @(posedge clk);
    #1;
    check("len0_idle", {31'b0, busy}, 0);
    wait_idle("len0");

    // Reset in the middle of SEND after two bytes.
    ready_mode = 0;
    begin
      int target;
      target = hs_count + 2;
      start_xfer(32'h10, 2, 1);
      for (int c = 0; c < 100 && hs_count < target; c++) begin
        @(posedge clk);
        #1;
      end
      check("pre_reset_bytes", hs_count, target);
    end
    reset  = 1'b1;
    mon_en = 0;
    exp_q.delete();
    done_exp_next = 0;
    stall_prev    = 0;
    @(posedge clk);
    #1;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_valid", {31'b0, out_valid}, 0);
    check("abort_last", {31'b0, out_last}, 0);
    check("abort_data", {24'b0, out_data}, 0);
    check("abort_addr", mem_addr, 0);
    reset  = 1'b0;
    mon_en = 1;
    @(posedge clk);
    #1;
    check("abort_no_done", {31'b0, done}, 0);
    start_xfer(32'h10, 1, 1);
    wait_idle("after_reset");

    // Start while busy is ignored.
    ready_mode = 2;
    start_xfer(32'h10, 2, 1);
    start_xfer(32'h200, 3, 0);
    wait_idle("restart_ignored");

    // Whole memory once, wrapping through index 0.
    ready_mode = 0;
    start_xfer(32'h800, DEPTH, 1);
    wait_idle("full_depth");

    // Randomized transfers.
    for (int t = 0; t < 25; t++) begin
      ready_mode = $urandom_range(0, 2);
      start_xfer($urandom, $urandom_range(1, 6), 1);
      wait_idle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_stream_reader.md
Name: dmem_stream_reader

Overview:
- Read-only DMA-style streamer on the data memory's read-only port 1 (addr1/rd1).
- On a start pulse it walks a block of consecutive words from a byte base address.
- Each word is serialised into bytes, little-endian, onto a valid/ready byte stream toward a UART/display sink.
- Runs alongside the CPU without touching the write port.

Parameters:
- DEPTH_WORDS, 1024, words in data memory; word index wraps modulo this. Power of two.
- LEN_W, 11, width of the length field; range 0..DEPTH_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  32  byte address of first word; bits [1:0] ignored.
- len_words  in  LEN_W  number of words to stream.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of transfer.
- mem_addr  out  32  to dmem addr1; always {zeros, word_idx, 2'b00}.
- mem_rdata  in  32  from dmem rd1; combinational read of mem_addr.
- out_valid  out  1  byte available.
- out_data  out  8  byte payload.
- out_ready  in  1  sink accepts byte.
- out_last  out  1  high with the final byte of the transfer.

Behaviour:
- Reset (synchronous): state=IDLE; busy, done, out_valid, out_last=0; out_data=0; word_idx=0; mem_addr=0.
- Reset mid-transfer aborts immediately; no done pulse.
- Internal registers:
  - word_idx: clog2(DEPTH_WORDS) bits.
  - words_left: LEN_W bits.
  - byte_idx: 2 bits.
  - word_buf: 32 bits.
- State machine: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start && len_words!=0: word_idx <= base_addr[clog2(DEPTH)+1:2]; words_left <= len_words; go FETCH.
  - start && len_words==0: go DONE, so done is high the next cycle with no bytes sent.
  - start in any other state is ignored.
- FETCH (one cycle): word_buf <= mem_rdata (dmem read is combinational, so data is valid this cycle); byte_idx <= 0; go SEND.
- SEND:
  - out_valid=1.
  - out_data=word_buf[8*byte_idx +: 8], so byte 0 = bits [7:0] (little-endian).
  - out_data and out_last stay stable while out_valid && !out_ready.
- SEND, on handshake (out_valid && out_ready):
  - byte_idx<3: byte_idx++.
  - byte_idx==3 && words_left>1: words_left--; word_idx++ (wraps DEPTH_WORDS-1 -> 0); go FETCH.
  - byte_idx==3 && words_left==1: go DONE.
- out_last = (state==SEND) && byte_idx==3 && words_left==1.
- DONE: done=1 for exactly one cycle; busy=1; go IDLE.
- mem_addr is driven from the registered word_idx in every state. It is stable during SEND and never glitches within a cycle.
- Timing:
  - start sampled at edge k → FETCH in cycle k+1 → first out_valid in cycle k+2.
  - With out_ready held high: 5 cycles per word; N words complete in 5N cycles after start, then done one cycle later.
- Backpressure: out_ready low holds SEND indefinitely with no state change.
- len_words=DEPTH_WORDS streams every word once, wrapping to index 0 as needed.
- len_words > DEPTH_WORDS is illegal; behaviour is wrap-around repeat, not checked.
- Memory writes by the CPU during a transfer: the word is sampled in its FETCH cycle; later writes are not reflected.

Test Plan:
- RAM[4]=0xDDCCBBAA, RAM[5]=0x44332211; start with base_addr=0x10, len_words=2, out_ready=1.
  → bytes AA,BB,CC,DD,11,22,33,44; out_last only on 44; mem_addr 0x10 then 0x14; done one cycle after the 44 handshake; busy high throughout.
- Same setup, out_ready toggled 1,0,0,1,...
  → identical byte sequence; out_data/out_last unchanged during stalls; no duplicated or dropped bytes.
- base_addr=0xFFC, len_words=2, RAM[1023]=0x01020304, RAM[0]=0x0A0B0C0D.
  → mem_addr 0xFFC then 0x000; bytes 04,03,02,01,0D,0C,0B,0A.
- start with len_words=0 → no out_valid; done pulses the cycle after start; busy high for that one cycle only.
- Reset asserted while in SEND after 2 bytes → next cycle all outputs 0, state IDLE, no done.
  - A new start with base_addr=0x10, len_words=1 then streams AA,BB,CC,DD normally.
- start pulsed again while busy → ignored; the original transfer completes unchanged with a single done pulse.
